wall_tracker: RTL and testbench
===============================

WALL_TRACKER -- requirements
Module: wall_tracker

Interface
REQ-001 Parameter SPEED_W, 6, width of speed input.
REQ-002 Parameter WHEEL_W, 8, width of signed wheel outputs; SHALL be >= SPEED_W+1.
REQ-003 Parameter DEBOUNCE_CYC, 16, consecutive stable samples needed to change a filtered sensor.
REQ-004 Parameter TURN_CYC, 64, minimum cycles spent in TURN_AWAY.
REQ-005 Parameter LOST_CYC, 256, maximum cycles in TURN_TOWARD before giving up.
REQ-006 Parameter RAMP_STEP, 1, maximum per-cycle change of each wheel output.
REQ-007 Parameter FOLLOW_LEFT, 0, 0 = follow wall on right side, 1 = left side.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 enable  in  1  1 = run; 0 = stop and return to IDLE.
REQ-011 sensor_left, sensor_right, sensor_wall  in  1 each  asynchronous, active-low obstacle detectors (0 = obstacle).
REQ-012 speed  in  SPEED_W  unsigned cruise magnitude V.
REQ-013 wheel_left, wheel_right  out  WHEEL_W signed  registered wheel commands.
REQ-014 state  out  3  current FSM state: IDLE=0, SEEK=1, FOLLOW=2, TURN_AWAY=3, TURN_TOWARD=4.

Function
REQ-015 Each sensor SHALL pass a 2-flop synchroniser, then a debouncer whose filtered value changes on the edge taking the DEBOUNCE_CYC-th consecutive sample differing from it; any matching sample clears the count.
REQ-016 Side sensor = sensor_right when FOLLOW_LEFT=0, else sensor_left; the other lateral sensor is ignored by the FSM.
REQ-017 wall = filtered sensor_wall==0; side = filtered side sensor==0; the FSM SHALL use only filtered values.
REQ-018 V = speed zero-extended to WHEEL_W; H = V>>1.
REQ-019 Targets (left,right): IDLE (0,0); SEEK and FOLLOW (V,V); TURN_AWAY (-V,+V) for FOLLOW_LEFT=0, (+V,-V) for 1; TURN_TOWARD (V,H) for FOLLOW_LEFT=0, (H,V) for 1.
REQ-020 Each cycle each wheel output SHALL move toward its target by RAMP_STEP, landing exactly on target when |target-output| <= RAMP_STEP; never overshoot, never wrap.
REQ-021 speed changes SHALL retarget immediately; the ramp limits the response.
REQ-022 IDLE -> SEEK when enable=1.
REQ-023 SEEK: wall -> TURN_AWAY; else side -> FOLLOW.
REQ-024 FOLLOW: wall -> TURN_AWAY; else !side -> TURN_TOWARD.
REQ-025 TURN_AWAY: turn timer counts from 0 on entry; exit only when timer >= TURN_CYC-1 and !wall, to FOLLOW if side else SEEK.
REQ-026 TURN_TOWARD: wall -> TURN_AWAY; else side -> FOLLOW; else timer reaching LOST_CYC-1 -> SEEK.
REQ-027 Priority each cycle: reset > enable=0 > wall > side > timer.
REQ-028 enable=0 in any state SHALL force IDLE on the next edge; outputs then ramp to 0 per REQ-020.
REQ-029 Timer SHALL clear on every state change and saturate, never wrap.
REQ-030 FSM latency: state changes on the edge after the filtered value changes.

Reset
REQ-031 On reset: state=IDLE, wheel_left=wheel_right=0, filtered sensors=1 (clear), synchroniser flops=1, debounce counters and timer=0, all on the same edge, overriding any operation in progress (including mid-ramp or mid-turn).

Verification (DEBOUNCE_CYC=4, TURN_CYC=8, LOST_CYC=16, RAMP_STEP=4, other params default)
REQ-032 Reset with wheels at 40 -> next edge wheels 0, state 0; held reset ignores sensors.
REQ-033 enable=1, speed=63, sensors all 1 -> state 1; wheels 0,4,8,...,60,63 over 16 cycles, then hold 63.
REQ-034 sensor_wall low 3 cycles -> no state change; low 6 cycles -> state 3, wheels ramp to (-63,+63).
REQ-035 In TURN_AWAY, wall clears after 2 cycles -> state stays 3 for 8 cycles total, then 1 (sensor_right=1) or 2 (sensor_right=0).
REQ-036 FOLLOW at speed 63, sensor_right goes 1 -> state 4, targets (63,31); sensor stays 1 -> state 1 after 16 cycles; a repeat with sensor_right back to 0 -> state 2.
REQ-037 enable dropped mid-TURN_AWAY -> state 0 next edge, wheels step by 4 to (0,0); FOLLOW_LEFT=1 build mirrors REQ-034/036 targets.

Source files
------------

// File: rtl/wall_tracker.sv
`default_nettype none
// =============================================================================
// wall_tracker: debounced wall-following motor controller with ramped wheels
// rev 1.0
// =============================================================================
module wall_tracker #(
   parameter int SPEED_W      = 6,
   parameter int WHEEL_W      = 8,
   parameter int DEBOUNCE_CYC = 16,
   parameter int TURN_CYC     = 64,
   parameter int LOST_CYC     = 256,
   parameter int RAMP_STEP    = 1,
   parameter int FOLLOW_LEFT  = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      sensor_left,
   input  logic                      sensor_right,
   input  logic                      sensor_wall,
   input  logic [SPEED_W-1:0]        speed,
   output logic signed [WHEEL_W-1:0] wheel_left,
   output logic signed [WHEEL_W-1:0] wheel_right,
   output logic [2:0]                state
);

   localparam int CNT_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int TMR_CYC = (LOST_CYC > TURN_CYC) ? LOST_CYC : TURN_CYC;
   localparam int TMR_W   = $clog2(TMR_CYC) + 1;
   localparam logic [CNT_W-1:0]        C_CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [TMR_W-1:0]        C_TURN_END = TMR_W'(TURN_CYC - 1);
   localparam logic [TMR_W-1:0]        C_LOST_END = TMR_W'(LOST_CYC - 1);
   localparam logic [TMR_W-1:0]        C_TMR_MAX  = '1;
   localparam logic signed [WHEEL_W:0] C_STEP     = (WHEEL_W+1)'(RAMP_STEP);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_SEEK        = 3'd1,
      S_FOLLOW      = 3'd2,
      S_TURN_AWAY   = 3'd3,
      S_TURN_TOWARD = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [TMR_W-1:0]           timer_q, timer_d;
   logic [2:0]                 sync1_q, sync1_d, sync2_q, sync2_d;
   logic [2:0]                 filt_q, filt_d;
   logic [CNT_W-1:0]           cnt_q [3];
   logic [CNT_W-1:0]           cnt_d [3];
   logic signed [WHEEL_W-1:0]  wl_q, wl_d, wr_q, wr_d;
   logic signed [WHEEL_W-1:0]  v, h, tgt_l, tgt_r;
   logic                       wall, side;

   // Move cur toward tgt by at most RAMP_STEP; the extra bit keeps the
   // difference from wrapping at the signed extremes.
   function automatic logic signed [WHEEL_W-1:0] ramp(
      input logic signed [WHEEL_W-1:0] cur,
      input logic signed [WHEEL_W-1:0] tgt
   );
      logic signed [WHEEL_W:0] cur_x, tgt_x, diff, nxt;
      cur_x = {cur[WHEEL_W-1], cur};
      tgt_x = {tgt[WHEEL_W-1], tgt};
      diff  = tgt_x - cur_x;
      if (diff > C_STEP) begin
         nxt = cur_x + C_STEP;
      end else if (diff < -C_STEP) begin
         nxt = cur_x - C_STEP;
      end else begin
         nxt = tgt_x;
      end
      return nxt[WHEEL_W-1:0];
   endfunction

   // Bit 0 = left, 1 = right, 2 = wall; all active-low, idle high.
   always_comb begin
      sync1_d = {sensor_wall, sensor_right, sensor_left};
      sync2_d = sync1_q;
      filt_d  = filt_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (cnt_q[i] == C_CNT_LAST) begin
               filt_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign wall = ~filt_q[2];
   assign side = (FOLLOW_LEFT != 0) ? ~filt_q[0] : ~filt_q[1];

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   state_d = S_SEEK;
            S_SEEK: begin
               if (wall)      state_d = S_TURN_AWAY;
               else if (side) state_d = S_FOLLOW;
            end
            S_FOLLOW: begin
               if (wall)       state_d = S_TURN_AWAY;
               else if (!side) state_d = S_TURN_TOWARD;
            end
            S_TURN_AWAY: begin
               if (!wall && (timer_q >= C_TURN_END)) begin
                  state_d = side ? S_FOLLOW : S_SEEK;
               end
            end
            S_TURN_TOWARD: begin
               if (wall)                         state_d = S_TURN_AWAY;
               else if (side)                    state_d = S_FOLLOW;
               else if (timer_q >= C_LOST_END)   state_d = S_SEEK;
            end
            default:  state_d = S_IDLE;
         endcase
      end

      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == C_TMR_MAX) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Targets follow the state currently held; the ramp absorbs any jump.
   always_comb begin
      v     = {{(WHEEL_W-SPEED_W){1'b0}}, speed};
      h     = {1'b0, v[WHEEL_W-1:1]};
      tgt_l = '0;
      tgt_r = '0;
      case (state_q)
         S_SEEK, S_FOLLOW: begin
            tgt_l = v;
            tgt_r = v;
         end
         S_TURN_AWAY: begin
            if (FOLLOW_LEFT != 0) begin
               tgt_l = v;
               tgt_r = -v;
            end else begin
               tgt_l = -v;
               tgt_r = v;
            end
         end
         S_TURN_TOWARD: begin
            if (FOLLOW_LEFT != 0) begin
               tgt_l = h;
               tgt_r = v;
            end else begin
               tgt_l = v;
               tgt_r = h;
            end
         end
         default: begin
            tgt_l = '0;
            tgt_r = '0;
         end
      endcase
      wl_d = ramp(wl_q, tgt_l);
      wr_d = ramp(wr_q, tgt_r);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
         filt_q  <= 3'b111;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         wl_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
         wl_q    <= wl_d;
         wr_q    <= wr_d;
      end
   end

   assign wheel_left  = wl_q;
   assign wheel_right = wr_q;
   assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_wall_tracker.sv
`default_nettype none
// =============================================================================
// tb_wall_tracker: scoreboard bench for right- and left-following builds
// rev 1.0
// =============================================================================
module tb_wall_tracker;

   localparam int STEP = 4;

   logic clk = 1'b0;
   logic reset, enable, wall_n, side_n;
   logic [5:0] speed;
   logic signed [7:0] wl_r, wr_r, wl_l, wr_l;
   logic [2:0] st_r, st_l;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      int st;
      int wl;
      int wr;
   } exp_t;
   exp_t q[$];

   int m_st = 0;
   int m_wl = 0;
   int m_wr = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Right-following build; its ignored left sensor sees the inverse.
   wall_tracker #(
      .SPEED_W(6), .WHEEL_W(8), .DEBOUNCE_CYC(4), .TURN_CYC(8),
      .LOST_CYC(16), .RAMP_STEP(STEP), .FOLLOW_LEFT(0)
   ) dut_r (
      .clk(clk), .reset(reset), .enable(enable),
      .sensor_left(~side_n), .sensor_right(side_n), .sensor_wall(wall_n),
      .speed(speed), .wheel_left(wl_r), .wheel_right(wr_r), .state(st_r)
   );

   // Left-following build sees the mirrored world, so its wheels swap.
   wall_tracker #(
      .SPEED_W(6), .WHEEL_W(8), .DEBOUNCE_CYC(4), .TURN_CYC(8),
      .LOST_CYC(16), .RAMP_STEP(STEP), .FOLLOW_LEFT(1)
   ) dut_l (
      .clk(clk), .reset(reset), .enable(enable),
      .sensor_left(side_n), .sensor_right(~side_n), .sensor_wall(wall_n),
      .speed(speed), .wheel_left(wl_l), .wheel_right(wr_l), .state(st_l)
   );

   task automatic chk(input string name, input int c, input logic signed [31:0] act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, c, act, expv);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("r_state", e.cyc, 32'(signed'({1'b0, st_r})), e.st);
         chk("r_wheel_left", e.cyc, 32'(wl_r), e.wl);
         chk("r_wheel_right", e.cyc, 32'(wr_r), e.wr);
         chk("l_state", e.cyc, 32'(signed'({1'b0, st_l})), e.st);
         chk("l_wheel_left", e.cyc, 32'(wl_l), e.wr);
         chk("l_wheel_right", e.cyc, 32'(wr_l), e.wl);
      end
   end

   function automatic int ramp(input int cur, input int tgt);
      if (tgt - cur > STEP)  return cur + STEP;
      if (tgt - cur < -STEP) return cur - STEP;
      return tgt;
   endfunction

   // Right-following targets; state fixed by hand, wheels by this model.
   task automatic target(input int st, output int tl, output int tr);
      int v;
      v = int'(speed);
      case (st)
         1, 2:    begin tl = v;  tr = v;      end
         3:       begin tl = -v; tr = v;      end
         4:       begin tl = v;  tr = v / 2;  end
         default: begin tl = 0;  tr = 0;      end
      endcase
   endtask

   task automatic step(input int nst);
      int tl, tr;
      exp_t e;
      if (reset) begin
         m_st = 0;
         m_wl = 0;
         m_wr = 0;
      end else begin
         target(m_st, tl, tr);
         m_wl = ramp(m_wl, tl);
         m_wr = ramp(m_wr, tr);
         m_st = nst;
      end
      e.cyc = cyc + 1;
      e.st  = m_st;
      e.wl  = m_wl;
      e.wr  = m_wr;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int n, input int nst);
      repeat (n) step(nst);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; wall_n = 1'b1; side_n = 1'b1; speed = 6'd63;
      run(3, 0);

      // ramp to 40, then reset mid-ramp with obstacles present
      reset = 1'b0; enable = 1'b1;
      step(1); run(10, 1);
      reset = 1'b1; wall_n = 1'b0; side_n = 1'b0;
      run(4, 0);
      reset = 1'b0; wall_n = 1'b1; side_n = 1'b1;

      // full ramp 0,4,...,60,63 then hold
      step(1); run(19, 1);

      // speed retarget down and back up
      speed = 6'd20; run(12, 1);
      speed = 6'd63; run(12, 1);

      // wall glitch shorter than the debounce window
      wall_n = 1'b0; run(3, 1);
      wall_n = 1'b1; run(6, 1);

      // long wall: turn away fully, timer saturates, exit to SEEK
      wall_n = 1'b0; run(6, 1); run(40, 3);
      wall_n = 1'b1; run(6, 3); step(1);
      run(33, 1);

      // wall clears early: minimum turn time, exit to FOLLOW
      wall_n = 1'b0; side_n = 1'b0; run(6, 1);
      wall_n = 1'b1; step(3); run(7, 3); step(2);
      run(4, 2);

      // side lost: TURN_TOWARD for 16 cycles then SEEK
      side_n = 1'b1; run(6, 2); step(4); run(15, 4); step(1);

      // reacquire side, lose it, regain it during TURN_TOWARD
      side_n = 1'b0; run(6, 1); step(2);
      side_n = 1'b1; run(6, 2);
      side_n = 1'b0; step(4); run(5, 4); step(2);
      run(3, 2);

      // enable dropped mid-turn: IDLE next edge, wheels ramp to zero
      wall_n = 1'b0; run(6, 2); step(3); run(2, 3);
      enable = 1'b0; step(0); run(20, 0);

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
